sprite_mixer: RTL and testbench

Parametrised N-channel sprite compositor between the VGA timing generator and `pattern_gen`. For each pixel it computes a ROM address per sprite channel from a double-buffered per-sprite configuration (position, size, stride, integer scale, horizontal flip, enable). It waits a configurable ROM latency, then merges the sprites over the background tile colour by fixed priority with colour-key transparency. An optional per-frame sprite collision detector can be compiled in.

---
 rtl/sprite_mixer_if.sv | 49 ++++
 rtl/sprite_mixer.sv | 174 +++++++++++++++++
 tb/tb_sprite_mixer.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_mixer_if.sv
// Pixel, configuration, ROM and output signals of the sprite compositor.
// The slave modport is the mixer; the master modport is the timing/config/ROM side.
interface sprite_mixer_if #(
    parameter int NUM_SPRITES = 2,
    parameter int ADDR_W      = 14
);
    localparam int SEL_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

    logic [9:0]                    col;
    logic [9:0]                    row;
    logic                          valid;
    logic                          frame_tick;

    logic                          cfg_we;
    logic [SEL_W-1:0]              cfg_sel;
    logic [9:0]                    cfg_x;
    logic [9:0]                    cfg_y;
    logic [6:0]                    cfg_w;
    logic [6:0]                    cfg_h;
    logic [7:0]                    cfg_stride;
    logic [ADDR_W-1:0]             cfg_base;
    logic [1:0]                    cfg_scale;
    logic                          cfg_flip;
    logic                          cfg_en;

    logic [NUM_SPRITES*ADDR_W-1:0] spr_addr;
    logic [NUM_SPRITES*6-1:0]      spr_rgb;
    logic [5:0]                    bg_rgb;

    logic [5:0]                    rgb_out;
    logic                          out_valid;
    logic [NUM_SPRITES-1:0]        collision;

    modport master (
        output col, row, valid, frame_tick,
        output cfg_we, cfg_sel, cfg_x, cfg_y, cfg_w, cfg_h, cfg_stride, cfg_base,
        output cfg_scale, cfg_flip, cfg_en,
        output spr_rgb, bg_rgb,
        input  spr_addr, rgb_out, out_valid, collision
    );

    modport slave (
        input  col, row, valid, frame_tick,
        input  cfg_we, cfg_sel, cfg_x, cfg_y, cfg_w, cfg_h, cfg_stride, cfg_base,
        input  cfg_scale, cfg_flip, cfg_en,
        input  spr_rgb, bg_rgb,
        output spr_addr, rgb_out, out_valid, collision
    );
endinterface

// File: rtl/sprite_mixer.sv
// N-channel sprite compositor: double-buffered config, per-channel ROM address, priority/colour-key merge.
// Latency: spr_addr 1 cycle, rgb_out/out_valid ROM_LAT+2 cycles after the pixel; one pixel per clock.
// No backpressure (free-running video). Define SPRITE_MIXER_COLLISION_EN for per-frame collision flags.
module sprite_mixer #(
    parameter int          NUM_SPRITES = 2,
    parameter int          ROM_LAT     = 2,
    parameter int          ADDR_W      = 14,
    parameter logic [5:0]  KEY_RGB     = 6'b110011
) (
    input  logic           clk,
    input  logic           rst,
    sprite_mixer_if.slave  bus
);
    localparam int DEPTH = ROM_LAT + 1;

    typedef struct packed {
        logic [9:0]        x;
        logic [9:0]        y;
        logic [6:0]        w;
        logic [6:0]        h;
        logic [7:0]        stride;
        logic [ADDR_W-1:0] base;
        logic [1:0]        scale;
        logic              flip;
        logic              en;
    } cfg_t;

    cfg_t pend_q [NUM_SPRITES];
    cfg_t pend_d [NUM_SPRITES];
    cfg_t act_q  [NUM_SPRITES];
    cfg_t act_d  [NUM_SPRITES];
    cfg_t wr_cfg;
    logic wr_ok;

    logic [NUM_SPRITES-1:0]             hit_c;
    logic [NUM_SPRITES-1:0][ADDR_W-1:0] addr_c;
    logic [NUM_SPRITES-1:0][ADDR_W-1:0] addr_q, addr_d;
    logic [DEPTH-1:0][NUM_SPRITES-1:0]  hit_sr_q, hit_sr_d;
    logic [DEPTH-1:0]                   vld_sr_q, vld_sr_d;

    logic [NUM_SPRITES-1:0] opaque;
    logic [NUM_SPRITES-1:0] hit_last;
    logic                   vld_last;
    logic [5:0]             pix;
    logic [5:0]             rgb_q, rgb_d;
    logic                   out_valid_q, out_valid_d;

    // Pending bank write; a same-cycle frame_tick copies the freshly written value straight through.
    always_comb begin
        wr_cfg = '{x: bus.cfg_x, y: bus.cfg_y, w: bus.cfg_w, h: bus.cfg_h,
                   stride: bus.cfg_stride, base: bus.cfg_base, scale: bus.cfg_scale,
                   flip: bus.cfg_flip, en: bus.cfg_en};
        wr_ok  = bus.cfg_we && (int'(bus.cfg_sel) < NUM_SPRITES);
        pend_d = pend_q;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (wr_ok && (int'(bus.cfg_sel) == i)) begin
                pend_d[i] = wr_cfg;
            end
        end
        act_d = bus.frame_tick ? pend_d : act_q;
    end

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_ch
        logic [1:0]  shamt;
        logic [10:0] dx, dy, wsz, hsz;
        logic [6:0]  lx, ly, xo;
        logic [14:0] prod;
        logic        hit;
        logic [ADDR_W-1:0] addr;

        // 11-bit offsets: a sprite running past 1023 is clipped because col/row never exceed 1023.
        always_comb begin
            shamt = (act_q[g].scale == 2'd3) ? 2'd2 : act_q[g].scale;
            dx    = {1'b0, bus.col} - {1'b0, act_q[g].x};
            dy    = {1'b0, bus.row} - {1'b0, act_q[g].y};
            wsz   = {4'b0, act_q[g].w} << shamt;
            hsz   = {4'b0, act_q[g].h} << shamt;
            hit   = act_q[g].en && (bus.col >= act_q[g].x) && (dx < wsz)
                                && (bus.row >= act_q[g].y) && (dy < hsz);
            lx    = 7'(dx >> shamt);
            ly    = 7'(dy >> shamt);
            xo    = act_q[g].flip ? (act_q[g].w - 7'd1 - lx) : lx;
            prod  = {8'b0, ly} * {7'b0, act_q[g].stride};
            addr  = hit ? (act_q[g].base + ADDR_W'(prod) + ADDR_W'(xo)) : '0;
        end

        assign hit_c[g]  = hit;
        assign addr_c[g] = addr;
    end

    always_comb begin
        addr_d      = addr_c;
        hit_sr_d    = hit_sr_q;
        vld_sr_d    = vld_sr_q;
        hit_sr_d[0] = hit_c;
        vld_sr_d[0] = bus.valid;
        for (int k = 1; k < DEPTH; k++) begin
            hit_sr_d[k] = hit_sr_q[k-1];
            vld_sr_d[k] = vld_sr_q[k-1];
        end
    end

    // Merge: walk from lowest priority upward so the lowest-index opaque channel wins.
    always_comb begin
        hit_last = hit_sr_q[DEPTH-1];
        vld_last = vld_sr_q[DEPTH-1];
        opaque   = '0;
        pix      = bus.bg_rgb;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            opaque[i] = hit_last[i] && (bus.spr_rgb[i*6 +: 6] != KEY_RGB);
            if (opaque[i]) begin
                pix = bus.spr_rgb[i*6 +: 6];
            end
        end
        rgb_d       = vld_last ? pix : 6'd0;
        out_valid_d = vld_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q      <= '{default: '0};
            act_q       <= '{default: '0};
            addr_q      <= '0;
            hit_sr_q    <= '0;
            vld_sr_q    <= '0;
            rgb_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            act_q       <= act_d;
            addr_q      <= addr_d;
            hit_sr_q    <= hit_sr_d;
            vld_sr_q    <= vld_sr_d;
            rgb_q       <= rgb_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.spr_addr  = addr_q;
    assign bus.rgb_out   = rgb_q;
    assign bus.out_valid = out_valid_q;

`ifdef SPRITE_MIXER_COLLISION_EN
    logic [NUM_SPRITES-1:0] acc_q, acc_d;
    logic [NUM_SPRITES-1:0] coll_q, coll_d;
    logic [NUM_SPRITES-1:0] coll_now;

    // A collision needs at least two opaque channels: clearing the lowest set bit leaves a nonzero value.
    always_comb begin
        coll_now = (vld_last && (|(opaque & (opaque - NUM_SPRITES'(1))))) ? opaque : '0;
        acc_d    = acc_q | coll_now;
        coll_d   = coll_q;
        if (bus.frame_tick) begin
            coll_d = acc_d;
            acc_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            coll_q <= '0;
        end else begin
            acc_q  <= acc_d;
            coll_q <= coll_d;
        end
    end

    assign bus.collision = coll_q;
`else
    assign bus.collision = '0;
`endif

endmodule

// File: tb/tb_sprite_mixer.sv
// Self-checking bench for sprite_mixer: reference model of banks/hit/address/merge feeding a scoreboard,
// a behavioural ROM driven by the DUT addresses, directed scenarios plus a random back-to-back stream.
module tb_sprite_mixer;
    localparam int         NS  = 2;
    localparam int         RL  = 2;
    localparam int         AW  = 14;
    localparam logic [5:0] KEY = 6'b110011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sprite_mixer_if #(.NUM_SPRITES(NS), .ADDR_W(AW)) bif ();

    sprite_mixer #(.NUM_SPRITES(NS), .ROM_LAT(RL), .ADDR_W(AW), .KEY_RGB(KEY)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    typedef struct {
        int x; int y; int w; int h; int stride; int base; int scale; int flip; int en;
    } mcfg_t;
    typedef struct { int due; logic [NS*AW-1:0] addr; } aexp_t;
    typedef struct { int due; logic [5:0] rgb; logic vld; } pexp_t;

    mcfg_t m_pend [NS];
    mcfg_t m_act  [NS];
    aexp_t aq [$];
    pexp_t pq [$];
    logic [NS-1:0] m_acc  = '0;
    logic [NS-1:0] m_coll = '0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       force_en  [NS];
    logic [5:0] force_val [NS];
    logic [5:0] bg_val = 6'h15;
    assign bif.bg_rgb = bg_val;

    // Behavioural ROM: data appears ROM_LAT cycles after the address it was read with.
    logic [NS*AW-1:0] rpipe [RL];
    always @(posedge clk) begin
        rpipe[0] <= bif.spr_addr;
        for (int k = 1; k < RL; k++) rpipe[k] <= rpipe[k-1];
    end
    always_comb begin
        for (int ch = 0; ch < NS; ch++) begin
            bif.spr_rgb[ch*6 +: 6] = force_en[ch] ? force_val[ch]
                                   : 6'(rpipe[RL-1][ch*AW +: 6] + 6'(ch*7));
        end
    end

    function automatic void mhit(input mcfg_t c, input int col, input int row,
                                 output logic h, output logic [AW-1:0] a);
        int s, dx, dy, lx, ly;
        s  = (c.scale == 3) ? 2 : c.scale;
        dx = col - c.x;
        dy = row - c.y;
        h  = (c.en != 0) && (dx >= 0) && (dx < (c.w << s)) && (dy >= 0) && (dy < (c.h << s));
        lx = dx >>> s;
        ly = dy >>> s;
        a  = h ? AW'(c.base + ly * c.stride + ((c.flip != 0) ? (c.w - 1 - lx) : lx)) : '0;
    endfunction

    // Scoreboard monitor: compares every queued expectation at the cycle it falls due.
    always @(negedge clk) begin
        while (aq.size() > 0 && aq[0].due <= cyc) begin
            checks++;
            if (aq[0].due != cyc || bif.spr_addr !== aq[0].addr) begin
                errors++;
                $display("FAIL spr_addr cyc=%0d due=%0d got=%h exp=%h", cyc, aq[0].due, bif.spr_addr, aq[0].addr);
            end
            void'(aq.pop_front());
        end
        while (pq.size() > 0 && pq[0].due <= cyc) begin
            checks++;
            if (pq[0].due != cyc || bif.rgb_out !== pq[0].rgb || bif.out_valid !== pq[0].vld) begin
                errors++;
                $display("FAIL rgb_out cyc=%0d due=%0d got=%h/%b exp=%h/%b", cyc, pq[0].due,
                         bif.rgb_out, bif.out_valid, pq[0].rgb, pq[0].vld);
            end
            void'(pq.pop_front());
        end
    end

    task automatic drive_px(input int c, input int r, input logic v);
        logic [NS*AW-1:0] ea;
        logic [5:0]       er, d;
        logic [NS-1:0]    op;
        logic             h;
        logic [AW-1:0]    a;
        bif.col   = 10'(c);
        bif.row   = 10'(r);
        bif.valid = v;
        ea = '0; er = '0; op = '0;
        if (!rst) begin
            er = bg_val;
            for (int ch = NS - 1; ch >= 0; ch--) begin
                mhit(m_act[ch], c, r, h, a);
                ea[ch*AW +: AW] = a;
                d = force_en[ch] ? force_val[ch] : 6'(a[5:0] + 6'(ch*7));
                if (h && d != KEY) begin
                    er     = d;
                    op[ch] = 1'b1;
                end
            end
            if (!v) er = '0;
            if (v && $countones(op) >= 2) m_acc = m_acc | op;
        end
        aq.push_back('{cyc + 1, ea});
        pq.push_back('{cyc + RL + 2, er, v && !rst});
        if (rst) begin
            foreach (aq[i]) if (aq[i].due > cyc) aq[i].addr = '0;
            foreach (pq[i]) if (pq[i].due > cyc) begin pq[i].rgb = '0; pq[i].vld = 1'b0; end
            for (int ch = 0; ch < NS; ch++) begin
                m_pend[ch] = '{default: 0};
                m_act[ch]  = '{default: 0};
            end
            m_acc  = '0;
            m_coll = '0;
        end else begin
            if (bif.cfg_we && int'(bif.cfg_sel) < NS)
                m_pend[bif.cfg_sel] = '{int'(bif.cfg_x), int'(bif.cfg_y), int'(bif.cfg_w), int'(bif.cfg_h),
                                       int'(bif.cfg_stride), int'(bif.cfg_base), int'(bif.cfg_scale),
                                       int'(bif.cfg_flip), int'(bif.cfg_en)};
            if (bif.frame_tick) begin
                m_act = m_pend;
`ifdef SPRITE_MIXER_COLLISION_EN
                m_coll = m_acc;
`endif
                m_acc = '0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        repeat (RL + 3) drive_px(0, 0, 1'b0);
    endtask

    task automatic cfg_write(input int sel, input int x, input int y, input int w, input int h,
                             input int stride, input int base, input int scale, input int flip,
                             input int en, input logic tick);
        if (tick) flush();
        bif.cfg_sel    = 1'(sel);
        bif.cfg_x      = 10'(x);
        bif.cfg_y      = 10'(y);
        bif.cfg_w      = 7'(w);
        bif.cfg_h      = 7'(h);
        bif.cfg_stride = 8'(stride);
        bif.cfg_base   = AW'(base);
        bif.cfg_scale  = 2'(scale);
        bif.cfg_flip   = 1'(flip);
        bif.cfg_en     = 1'(en);
        bif.cfg_we     = 1'b1;
        bif.frame_tick = tick;
        drive_px(0, 0, 1'b0);
        bif.cfg_we     = 1'b0;
        bif.frame_tick = 1'b0;
        if (tick) begin
            checks++;
            if (bif.collision !== m_coll) begin
                errors++;
                $display("FAIL collision_wt got=%b exp=%b", bif.collision, m_coll);
            end
        end
    endtask

    task automatic do_tick();
        flush();
        bif.frame_tick = 1'b1;
        drive_px(0, 0, 1'b0);
        bif.frame_tick = 1'b0;
        checks++;
        if (bif.collision !== m_coll) begin
            errors++;
            $display("FAIL collision got=%b exp=%b", bif.collision, m_coll);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_px(5, 5, 1'b1);
        drive_px(6, 5, 1'b1);
        checks += 4;
        if (bif.rgb_out !== 6'd0)    begin errors++; $display("FAIL reset_rgb got=%h exp=00", bif.rgb_out); end
        if (bif.out_valid !== 1'b0)  begin errors++; $display("FAIL reset_vld got=%b exp=0", bif.out_valid); end
        if (bif.spr_addr !== '0)     begin errors++; $display("FAIL reset_addr got=%h exp=0", bif.spr_addr); end
        if (bif.collision !== '0)    begin errors++; $display("FAIL reset_coll got=%b exp=0", bif.collision); end
        rst = 1'b0;
        for (int i = 0; i < 12; i++) drive_px(10 + i, 3, 1'b1);
        // Mid-line reset: in-flight pixels must vanish.
        rst = 1'b1;
        drive_px(22, 3, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) drive_px(23 + i, 3, 1'b1);
        checks++;
        if (bif.rgb_out !== 6'h15) begin errors++; $display("FAIL reset_bg got=%h exp=15", bif.rgb_out); end
    endtask

    task automatic test_basic();
        cfg_write(0, 100, 50, 23, 30, 69, 0, 1, 0, 1, 1'b0);
        do_tick();
        drive_px(103, 53, 1'b1);
        checks++;
        if (bif.spr_addr[AW-1:0] !== AW'(70)) begin
            errors++; $display("FAIL basic_addr got=%0d exp=70", bif.spr_addr[AW-1:0]);
        end
        drive_px(146, 50, 1'b1);
        drive_px(145, 50, 1'b1);
        drive_px(100, 50, 1'b1);
        drive_px(99, 50, 1'b1);
        drive_px(120, 109, 1'b1);
        drive_px(120, 110, 1'b1);
        drive_px(120, 49, 1'b1);
        for (int c = 95; c < 150; c++) drive_px(c, 60, 1'b1);
    endtask

    task automatic test_flip();
        cfg_write(0, 100, 50, 23, 30, 69, 0, 1, 1, 1, 1'b1);
        drive_px(100, 50, 1'b1);
        checks++;
        if (bif.spr_addr[AW-1:0] !== AW'(22)) begin
            errors++; $display("FAIL flip_addr0 got=%0d exp=22", bif.spr_addr[AW-1:0]);
        end
        drive_px(145, 50, 1'b1);
        checks++;
        if (bif.spr_addr[AW-1:0] !== AW'(0)) begin
            errors++; $display("FAIL flip_addr45 got=%0d exp=0", bif.spr_addr[AW-1:0]);
        end
        for (int c = 98; c < 148; c += 3) drive_px(c, 61, 1'b1);
    endtask

    task automatic test_priority();
        cfg_write(1, 120, 70, 5, 5, 10, 200, 0, 0, 1, 1'b1);
        flush();
        force_en[0] = 1'b1; force_val[0] = KEY;
        force_en[1] = 1'b1; force_val[1] = 6'h2A;
        drive_px(122, 72, 1'b1);
        repeat (RL + 1) drive_px(0, 0, 1'b0);
        checks++;
        if (bif.rgb_out !== 6'h2A) begin errors++; $display("FAIL prio_key got=%h exp=2a", bif.rgb_out); end
        drive_px(110, 60, 1'b1);
        flush();
        force_val[0] = 6'h01;
        drive_px(122, 72, 1'b1);
        repeat (RL + 1) drive_px(0, 0, 1'b0);
        checks++;
        if (bif.rgb_out !== 6'h01) begin errors++; $display("FAIL prio_ch0 got=%h exp=01", bif.rgb_out); end
    endtask

    task automatic test_collision();
        do_tick();
`ifdef SPRITE_MIXER_COLLISION_EN
        checks++;
        if (bif.collision !== 2'b11) begin errors++; $display("FAIL coll_set got=%b exp=11", bif.collision); end
`endif
        drive_px(110, 60, 1'b1);
        drive_px(123, 73, 1'b0);
        do_tick();
        checks++;
        if (bif.collision !== 2'b00) begin errors++; $display("FAIL coll_clr got=%b exp=00", bif.collision); end
        force_en[0] = 1'b0;
        force_en[1] = 1'b0;
        flush();
    endtask

    task automatic test_cfg_timing();
        cfg_write(1, 300, 300, 8, 8, 16, 1000, 0, 0, 1, 1'b0);
        for (int i = 0; i < 6; i++) drive_px(120 + i, 72, 1'b1);
        drive_px(302, 302, 1'b1);
        do_tick();
        for (int i = 0; i < 6; i++) drive_px(120 + i, 72, 1'b1);
        drive_px(302, 302, 1'b1);
        cfg_write(1, 120, 70, 5, 5, 10, 200, 2, 1, 1, 1'b1);
        for (int i = 0; i < 24; i++) drive_px(118 + i, 75, 1'b1);
        // Clipping at the screen edge must never wrap to column/row 0.
        cfg_write(1, 1000, 1010, 127, 127, 255, 16000, 2, 0, 1, 1'b1);
        drive_px(1023, 1023, 1'b1);
        drive_px(2, 1015, 1'b1);
        drive_px(1005, 3, 1'b1);
    endtask

    task automatic test_back_to_back();
        int c, r;
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                cfg_write($urandom_range(0, NS - 1),
                          $urandom_range(0, 1) ? $urandom_range(80, 200) : $urandom_range(960, 1023),
                          $urandom_range(0, 1) ? $urandom_range(40, 160) : $urandom_range(960, 1023),
                          $urandom_range(1, 127), $urandom_range(1, 127), $urandom_range(0, 255),
                          $urandom_range(0, 16383), $urandom_range(0, 3), $urandom_range(0, 1),
                          ($urandom_range(0, 3) != 0) ? 1 : 0, 1'b0);
            end else if ($urandom_range(0, 79) == 0) begin
                do_tick();
            end else begin
                c = $urandom_range(0, 2) == 0 ? $urandom_range(0, 1023) : $urandom_range(80, 400);
                r = $urandom_range(0, 2) == 0 ? $urandom_range(0, 1023) : $urandom_range(40, 300);
                drive_px(c, r, $urandom_range(0, 9) != 0);
            end
        end
        do_tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int ch = 0; ch < NS; ch++) begin
            force_en[ch]  = 1'b0;
            force_val[ch] = '0;
            m_pend[ch]    = '{default: 0};
            m_act[ch]     = '{default: 0};
        end
        bif.col = '0; bif.row = '0; bif.valid = 1'b0; bif.frame_tick = 1'b0;
        bif.cfg_we = 1'b0; bif.cfg_sel = '0; bif.cfg_x = '0; bif.cfg_y = '0;
        bif.cfg_w = '0; bif.cfg_h = '0; bif.cfg_stride = '0; bif.cfg_base = '0;
        bif.cfg_scale = '0; bif.cfg_flip = 1'b0; bif.cfg_en = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_flip();
        test_priority();
        test_collision();
        test_cfg_timing();
        test_back_to_back();
        flush();
        for (int i = 0; i < 20 && (aq.size() > 0 || pq.size() > 0); i++) @(posedge clk);
        @(negedge clk);
        if (aq.size() > 0 || pq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending addr=%0d pix=%0d exp=0", aq.size(), pq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
